// File: rtl/rb_accum_pkg.sv
// rtl/rb_accum_pkg.sv - shared types and defaults for the redundant-binary accumulator
package rb_accum_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/hyb_adder.sv
// rtl/hyb_adder.sv - carry-free hybrid adder: (sp - sn) = (xp - xn) + y mod 2^W
module hyb_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_xp,
    input  logic [W-1:0] i_xn,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_sp,
    output logic [W-1:0] o_sn
);

    logic [W-2:0] w_c;

    // Per bit xp + y - xn = 2*c - s, so c shifted up is the positive
    // vector and s the negative one; no carry crosses a bit position.
    assign w_c  = (i_xp[W-2:0] & i_y[W-2:0])
                | (i_xp[W-2:0] & ~i_xn[W-2:0])
                | (i_y[W-2:0]  & ~i_xn[W-2:0]);
    assign o_sp = {w_c, 1'b0};
    assign o_sn = i_xp ^ i_y ^ i_xn;

endmodule

// File: rtl/rb_accum_ctrl.sv
// rtl/rb_accum_ctrl.sv - streams operands through hyb_adder, converts the sum once per job
// Optional signed-overflow flag: OVF_FLAG_EN.
module rb_accum_ctrl
    import rb_accum_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic             ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_acc_p;
    logic [W-1:0]     r_acc_n;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_out_data;
    logic [W-1:0]     w_sum_p;
    logic [W-1:0]     w_sum_n;
    logic             w_in_hs;

    hyb_adder #(.W(W)) u_hyb_adder (
        .i_xp (r_acc_p),
        .i_xn (r_acc_n),
        .i_y  (in_data),
        .o_sp (w_sum_p),
        .o_sn (w_sum_n)
    );

    assign w_in_hs  = in_valid && in_ready;
    assign out_data = r_out_data;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (len == '0) ? CONVERT : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_in_hs && (r_cnt == CNT_W'(1))) begin
                    w_state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc_p    <= '0;
            r_acc_n    <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc_p <= '0;
                        r_acc_n <= '0;
                        r_cnt   <= len;
                    end
                end
                ACCUM: begin
                    if (w_in_hs) begin
                        r_acc_p <= w_sum_p;
                        r_acc_n <= w_sum_n;
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                CONVERT: begin
                    r_out_data <= r_acc_p - r_acc_n;
                end
                default: ;
            endcase
        end
    end

`ifdef OVF_FLAG_EN
    logic [W+CNT_W-1:0] r_shadow;
    logic               r_ovf;
    logic [CNT_W:0]     w_shadow_hi;
    logic               w_out_of_range;

    // The exact sum fits in W signed bits only when every bit from W-1 up
    // is a copy of the sign.
    assign w_shadow_hi    = r_shadow[W+CNT_W-1:W-1];
    assign w_out_of_range = !((&w_shadow_hi) || (~|w_shadow_hi));
    assign ovf            = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shadow <= '0;
                    end
                end
                ACCUM: begin
                    if (w_in_hs) begin
                        r_shadow <= r_shadow + {{CNT_W{in_data[W-1]}}, in_data};
                    end
                end
                CONVERT: begin
                    r_ovf <= w_out_of_range;
                end
                default: ;
            endcase
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rb_accum_ctrl.sv
// tb/tb_rb_accum_ctrl.sv - directed self-checking bench for rb_accum_ctrl
module tb_rb_accum_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [7:0]  len       = 8'd0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_data   = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    logic        ovf;

`ifdef OVF_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    int n_checks   = 0;
    int n_fail     = 0;
    int ready_seen = 0;

    rb_accum_ctrl #(.W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready) ready_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send_op(input logic [15:0] d, input int gap);
        int t;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag, input logic [15:0] exp_data,
                              input logic exp_ovf, input int stall);
        check({tag, "_conv_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        for (int i = 0; i < stall; i++) begin
            start = 1'b1;
            len   = 8'd1;
            @(negedge clk);
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_data"}, {16'd0, out_data}, {16'd0, exp_data});
        end
        start     = 1'b0;
        len       = 8'd0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_job(8'd3);
        check("j1_busy", {31'd0, busy}, 32'd1);
        send_op(16'd5, 0);
        send_op(16'd27, 0);
        send_op(16'd100, 0);
        finish_job("j1", 16'h0084, 1'b0, 0);

        rs = ready_seen;
        start_job(8'd0);
        check("j0_busy", {31'd0, busy}, 32'd1);
        finish_job("j0", 16'h0000, 1'b0, 0);
        check("j0_no_ready", rs, ready_seen);

        start_job(8'd2);
        send_op(16'hFFFF, 0);
        send_op(16'h0002, 0);
        finish_job("wrap", 16'h0001, 1'b0, 0);

        start_job(8'd2);
        send_op(16'h7FFF, 0);
        send_op(16'h0001, 0);
        finish_job("ovf", 16'h8000, OVF_ON, 0);

        start_job(8'd4);
        send_op(16'h1000, 1);
        send_op(16'h0234, 2);
        start = 1'b1;
        len   = 8'd1;
        send_op(16'hF000, 1);
        start = 1'b0;
        len   = 8'd0;
        send_op(16'h0010, 3);
        finish_job("stall", 16'h0244, 1'b0, 3);
        @(negedge clk);
        check("stall_no_restart", {31'd0, busy}, 32'd0);

        start_job(8'd4);
        send_op(16'd1, 0);
        send_op(16'd2, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", {16'd0, out_data}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(8'd1);
        send_op(16'd9, 0);
        finish_job("post_rst", 16'd9, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
